psum_accum_ctrl: RTL and testbench

- Partial-sum read-modify-write controller directly upstream of the output memory address decoder; drives its psumctrl_* ports.
- Accepts partial-sum beats from the PE array. A "first" beat overwrites memory; every other beat reads the stored psum, adds the new value and writes the sum back.
- Tracks outstanding reads in an in-order pending queue and stalls on address hazards.
- Counts completed writes and pulses done when the programmed count is reached.

---
 rtl/psum_accum_ctrl.sv | 152 +++++++++++++++
 tb/tb_psum_accum_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: partial-sum read-modify-write controller with an in-order pending-read queue.
// PSUM_ACCUM_SAT_EN: when defined, accumulate sums saturate instead of wrapping.
module psum_accum_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PEND_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_num,
    input  logic [DATA_WIDTH-1:0] in_dat,
    input  logic [ADDR_WIDTH-1:0] in_add,
    input  logic                  in_first,
    input  logic                  in_vld,
    output logic                  in_rdy,
    output logic [ADDR_WIDTH-1:0] psumctrl_radd,
    output logic                  psumctrl_rden,
    input  logic [DATA_WIDTH-1:0] psumctrl_odat,
    input  logic                  psumctrl_ovld,
    output logic [ADDR_WIDTH-1:0] psumctrl_wadd,
    output logic                  psumctrl_wren,
    output logic [DATA_WIDTH-1:0] psumctrl_wdat,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int PW = $clog2(PEND_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] cfg_num_q, wr_cnt;
    logic                  iss_vld, iss_first;
    logic [ADDR_WIDTH-1:0] iss_add;
    logic [DATA_WIDTH-1:0] iss_dat;
    logic [ADDR_WIDTH-1:0] q_add [PEND_DEPTH];
    logic [DATA_WIDTH-1:0] q_dat [PEND_DEPTH];
    logic [PEND_DEPTH-1:0] q_v;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic                  wr_vld;
    logic [ADDR_WIDTH-1:0] wr_add;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic                  q_empty, q_full, pop, push, iss_mv, hazard, last, drained, accept, start_ok;
    logic [DATA_WIDTH-1:0] head_dat, raw_sum, acc_sum;

    assign q_empty  = ~|q_v;
    assign q_full   = &q_v;
    assign pop      = psumctrl_ovld && busy && !q_empty;
    assign push     = iss_vld && !iss_first;
    // a first beat may only claim the write port in a cycle with no read return
    assign iss_mv   = iss_vld && iss_first && !psumctrl_ovld;
    assign last     = (wr_cnt + ADDR_WIDTH'(wr_vld)) == cfg_num_q;
    assign drained  = !iss_vld && q_empty && !wr_vld;
    assign accept   = in_vld && in_rdy;
    assign start_ok = (state == IDLE) && cfg_start;

    assign psumctrl_rden = push;
    assign psumctrl_radd = iss_add;
    assign psumctrl_wren = wr_vld;
    assign psumctrl_wadd = wr_add;
    assign psumctrl_wdat = wr_dat;

    assign head_dat = q_dat[rd_ptr];
    assign raw_sum  = head_dat + psumctrl_odat;
`ifdef PSUM_ACCUM_SAT_EN
    logic ovf;
    assign ovf     = (head_dat[DATA_WIDTH-1] == psumctrl_odat[DATA_WIDTH-1]) &&
                     (raw_sum[DATA_WIDTH-1] != head_dat[DATA_WIDTH-1]);
    assign acc_sum = !ovf ? raw_sum :
                     head_dat[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
    assign acc_sum = raw_sum;
`endif

    always_comb begin
        hazard = (iss_vld && iss_add == in_add) || (wr_vld && wr_add == in_add);
        for (int i = 0; i < PEND_DEPTH; i++)
            hazard = hazard || (q_v[i] && q_add[i] == in_add);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE)  ? (cfg_start ? ((cfg_num == '0) ? DONE : RUN) : IDLE) :
                   (state == RUN)   ? (last ? DRAIN : RUN) :
                   (state == DRAIN) ? (drained ? DONE : DRAIN) : IDLE;
    end

    always_comb begin
        in_rdy = (state == RUN) && !iss_vld && !q_full && !hazard && !last;
        busy   = (state == RUN) || (state == DRAIN);
        done   = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_v    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < PEND_DEPTH; i++) begin
                q_add[i] <= '0;
                q_dat[i] <= '0;
            end
        end else begin
            if (push) begin
                q_add[wr_ptr] <= iss_add;
                q_dat[wr_ptr] <= iss_dat;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            q_v <= (q_v & ~(PEND_DEPTH'(pop) << rd_ptr)) | (PEND_DEPTH'(push) << wr_ptr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_num_q <= '0;
            wr_cnt    <= '0;
            err       <= 1'b0;
            iss_vld   <= 1'b0;
            iss_first <= 1'b0;
            iss_add   <= '0;
            iss_dat   <= '0;
            wr_vld    <= 1'b0;
            wr_add    <= '0;
            wr_dat    <= '0;
        end else begin
            if (start_ok)
                cfg_num_q <= cfg_num;
            wr_cnt  <= start_ok ? '0 : wr_cnt + ADDR_WIDTH'(wr_vld);
            err     <= !start_ok && (err || (psumctrl_ovld && q_empty));
            iss_vld <= accept || (iss_vld && iss_first && psumctrl_ovld);
            if (accept) begin
                iss_add   <= in_add;
                iss_dat   <= in_dat;
                iss_first <= in_first;
            end
            wr_vld <= pop || iss_mv;
            if (pop || iss_mv) begin
                wr_add <= pop ? q_add[rd_ptr] : iss_add;
                wr_dat <= pop ? acc_sum : iss_dat;
            end
        end
    end
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb_psum_accum_ctrl: scoreboard bench for psum_accum_ctrl with an in-order, variable-latency memory model.
module tb_psum_accum_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [AW-1:0] cfg_num = '0;
    logic [DW-1:0] in_dat = '0;
    logic [AW-1:0] in_add = '0;
    logic          in_first = 1'b0, in_vld = 1'b0, in_rdy;
    logic [AW-1:0] psumctrl_radd, psumctrl_wadd;
    logic          psumctrl_rden, psumctrl_wren;
    logic [DW-1:0] psumctrl_odat = '0, psumctrl_wdat;
    logic          psumctrl_ovld = 1'b0;
    logic          busy, done, err;

    psum_accum_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PEND_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num(cfg_num),
        .in_dat(in_dat), .in_add(in_add), .in_first(in_first), .in_vld(in_vld), .in_rdy(in_rdy),
        .psumctrl_radd(psumctrl_radd), .psumctrl_rden(psumctrl_rden),
        .psumctrl_odat(psumctrl_odat), .psumctrl_ovld(psumctrl_ovld),
        .psumctrl_wadd(psumctrl_wadd), .psumctrl_wren(psumctrl_wren), .psumctrl_wdat(psumctrl_wdat),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] add; logic [DW-1:0] dat; int acc_cyc; int lat; } exp_t;
    typedef struct { logic [DW-1:0] dat; int due; } rsp_t;

    exp_t          sb[$];
    rsp_t          rq[$];
    logic [DW-1:0] mem   [64];
    logic [DW-1:0] model [64];
    int n_chk = 0, n_err = 0, cyc = 0;
    int lat = 1, exp_lat = -1;
    bit rnd_lat = 0, hold = 0, force_ovld = 0, fire = 0;
    int rd_cnt = 0, wr_cnt_tb = 0, done_cnt = 0;
    int last_acc_cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0, prev_wr_cyc = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] accum(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef PSUM_ACCUM_SAT_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return s[DW-1:0];
    endfunction

    task automatic setmem(input int a, input logic [DW-1:0] v);
        mem[a]   = v;
        model[a] = v;
    endtask

    // one clock: observe at negedge, then drive the read-return port just after posedge
    task automatic tick();
        exp_t e;
        rsp_t r;
        @(negedge clk);
        fire = in_vld && in_rdy;
        if (fire) begin
            e.add        = in_add;
            e.dat        = in_first ? in_dat : accum(model[in_add[5:0]], in_dat);
            e.acc_cyc    = cyc;
            e.lat        = exp_lat;
            model[in_add[5:0]] = e.dat;
            sb.push_back(e);
            last_acc_cyc = cyc;
        end
        if (psumctrl_rden) begin
            r.dat = mem[psumctrl_radd[5:0]];
            r.due = cyc + (rnd_lat ? int'($urandom_range(1, 3)) : lat);
            rq.push_back(r);
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (psumctrl_wren) begin
            mem[psumctrl_wadd[5:0]] = psumctrl_wdat;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            wr_cnt_tb++;
            check("write_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_add", psumctrl_wadd, e.add);
                check("wr_dat", psumctrl_wdat, e.dat);
                if (e.lat >= 0) check("wr_latency", cyc - e.acc_cyc, e.lat);
            end
        end
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (force_ovld) begin
            psumctrl_ovld = 1'b1;
            psumctrl_odat = '0;
        end else if (!hold && rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            psumctrl_ovld = 1'b1;
            psumctrl_odat = r.dat;
        end else begin
            psumctrl_ovld = 1'b0;
            psumctrl_odat = $urandom;
        end
    endtask

    task automatic send(input int a, input logic [DW-1:0] d, input bit f);
        int n;
        n = 0;
        in_vld = 1'b1; in_add = a; in_dat = d; in_first = f;
        do begin
            tick();
            n++;
        end while (!fire && n < 100);
        check("accept_in_time", fire, 1);
        in_vld = 1'b0;
    endtask

    task automatic start(input int num);
        cfg_num = num;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n, d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < 300) begin
            tick();
            n++;
        end
        check(tag, done_cnt - d0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rd0, wr0, d0, nf;
        for (int i = 0; i < 64; i++) setmem(i, DW'(i * 3));
        repeat (3) tick();
        check("rst_in_rdy", in_rdy, 0);
        check("rst_rden", psumctrl_rden, 0);
        check("rst_wren", psumctrl_wren, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // two first beats: plain overwrites, no reads
        exp_lat = 2; rd0 = rd_cnt; d0 = done_cnt;
        start(2);
        check("t1_busy", busy, 1);
        send(5, 7, 1);
        send(6, 9, 1);
        wait_done("t1_done");
        check("t1_no_rden", rd_cnt - rd0, 0);
        check("t1_mem5", mem[5], 7);
        check("t1_mem6", mem[6], 9);
        check("t1_busy_low", busy, 0);
        repeat (2) tick();
        check("t1_done_once", done_cnt - d0, 1);

        // single accumulate, read latency 2
        setmem(3, 10); lat = 2; exp_lat = 4;
        start(1);
        send(3, 5, 0);
        wait_done("t2_done");
        check("t2_rd_lat", last_rd_cyc - last_acc_cyc, 1);
        check("t2_mem3", mem[3], 15);

        // back-to-back to the same address must wait for the write-back
        setmem(4, 100); lat = 3; exp_lat = -1;
        start(2);
        send(4, 11, 0);
        wr0 = wr_cnt_tb;
        send(4, 22, 0);
        check("t3_wb_before_accept", wr_cnt_tb - wr0, 1);
        check("t3_accept_after_wb", last_acc_cyc - last_wr_cyc, 1);
        wait_done("t3_done");
        check("t3_mem4", mem[4], 133);

        // queue fill with returns withheld
        lat = 1; hold = 1; rd0 = rd_cnt;
        for (int i = 0; i < 4; i++) setmem(10 + i, DW'(1000 * (i + 1)));
        start(4);
        for (int i = 0; i < 4; i++) send(10 + i, DW'(i + 1), 0);
        in_vld = 1'b1; in_add = 14; in_dat = 1; in_first = 1'b0;
        nf = 0;
        repeat (5) begin
            tick();
            nf += int'(fire);
        end
        in_vld = 1'b0;
        check("t4_full_block", nf, 0);
        check("t4_reads", rd_cnt - rd0, 4);
        hold = 0;
        wait_done("t4_done");
        check("t4_mem13", mem[13], 4004);

        // first beat held behind a read return
        lat = 2; setmem(20, 100); setmem(21, 0);
        start(2);
        send(20, 1, 0);
        send(21, 50, 1);
        wait_done("t5_done");
        check("t5_first_after_wb", last_wr_cyc - prev_wr_cyc, 1);

        // random accumulates over a small address range
        rnd_lat = 1;
        start(8);
        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 7)), DW'($urandom_range(0, 1000)), 0);
        wait_done("t6_done");
        rnd_lat = 0;
        for (int i = 0; i < 8; i++) check("t6_mem", mem[i], model[i]);

        // reset in the middle of a pass
        hold = 1;
        start(3);
        send(30, 5, 0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_rdy", in_rdy, 0);
        check("mid_rst_rden", psumctrl_rden, 0);
        check("mid_rst_radd", psumctrl_radd, 0);
        check("mid_rst_wren", psumctrl_wren, 0);
        check("mid_rst_wadd", psumctrl_wadd, 0);
        check("mid_rst_wdat", psumctrl_wdat, 0);
        check("mid_rst_busy", busy, 0);
        sb.delete();
        rq.delete();
        for (int i = 0; i < 64; i++) model[i] = mem[i];
        hold = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        rd0 = rd_cnt; wr0 = wr_cnt_tb;
        repeat (6) tick();
        check("post_rst_no_rden", rd_cnt - rd0, 0);
        check("post_rst_no_wren", wr_cnt_tb - wr0, 0);
        start(0);
        check("num0_not_busy", busy, 0);
        wait_done("num0_done");

        // read return with an empty queue sets a sticky error
        force_ovld = 1;
        tick();
        force_ovld = 0;
        tick();
        check("err_set", err, 1);
        tick();
        check("err_sticky", err, 1);
        start(1);
        check("err_clr", err, 0);
        send(50, 3, 1);
        wait_done("err_pass_done");

        // signed overflow at both ends
        lat = 1; setmem(40, 32'h7FFF_FFFF); setmem(41, 32'h8000_0000);
        start(2);
        send(40, 1, 0);
        send(41, 32'hFFFF_FFFF, 0);
        wait_done("ovf_done");
`ifdef PSUM_ACCUM_SAT_EN
        check("ovf_pos", mem[40], 32'h7FFF_FFFF);
        check("ovf_neg", mem[41], 32'h8000_0000);
`else
        check("ovf_pos", mem[40], 32'h8000_0000);
        check("ovf_neg", mem[41], 32'h7FFF_FFFF);
`endif
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
